// File: rtl/pri_decoder_demux_if.sv
// Bus bundle for the 1-to-4 channel demux: one encoded source side and four
// buffered consumer channels.
//
// Handshake: a transfer happens on a rising clock edge exactly when valid and
// ready are both high. On the source side that is iValid & oReady. On channel k
// it is oValid[k] & iReady[k]. The block holds a channel word stable while its
// valid is high and its ready is low. oReady depends combinationally on iSel
// and iReady.
interface pri_decoder_demux_if #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
);
    logic              iValid;
    logic [1:0]        iSel;
    logic [DATA_W-1:0] iData;
    logic              oReady;
    logic [3:0]        oValid;
    logic [3:0]        iReady;
    logic [DATA_W-1:0] oData0;
    logic [DATA_W-1:0] oData1;
    logic [DATA_W-1:0] oData2;
    logic [DATA_W-1:0] oData3;
    logic [3:0]        oLastSel;
    logic [CNT_W-1:0]  oAccCnt;

    // Environment side: drives the source word and the consumer readies.
    modport master (
        output iValid, iSel, iData, iReady,
        input  oReady, oValid, oData0, oData1, oData2, oData3, oLastSel, oAccCnt
    );

    // Demux side.
    modport slave (
        input  iValid, iSel, iData, iReady,
        output oReady, oValid, oData0, oData1, oData2, oData3, oLastSel, oAccCnt
    );
endinterface

// File: rtl/pri_decoder_demux.sv
// Routes one source word to one of four channels chosen by a 2-bit code.
// Each channel has a 1-deep output buffer. A stalled channel blocks only the
// words addressed to it. The per-channel EMPTY/FULL state is visible directly
// on oValid.
module pri_decoder_demux #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input logic               iClk,
    input logic               iRst_n,
    pri_decoder_demux_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chState_t;

    chState_t          chState     [4];
    chState_t          chStateNext [4];
    logic [DATA_W-1:0] chData      [4];
    logic [DATA_W-1:0] chDataNext  [4];
    logic [3:0]        lastSel;
    logic [3:0]        lastSelNext;
    logic [CNT_W-1:0]  accCnt;
    logic [CNT_W-1:0]  accCntNext;
    logic [3:0]        validVec;
    logic              acc;

    // The channel state is the valid flag exported to each consumer.
    always_comb begin
        validVec = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            validVec[k] = (chState[k] == FULL);
        end
    end

    // The selected channel can take a word if it is empty or is draining this cycle.
    assign bus.oReady = ~validVec[bus.iSel] | bus.iReady[bus.iSel];
    assign acc        = bus.iValid & bus.oReady;

    assign bus.oValid   = validVec;
    assign bus.oData0   = chData[0];
    assign bus.oData1   = chData[1];
    assign bus.oData2   = chData[2];
    assign bus.oData3   = chData[3];
    assign bus.oLastSel = lastSel;
    assign bus.oAccCnt  = accCnt;

    // Next-state logic. A write has priority over a drain, so a channel that
    // drains and refills in the same cycle stays FULL with no bubble.
    always_comb begin
        lastSelNext = lastSel;
        accCntNext  = accCnt;
        for (int k = 0; k < 4; k++) begin
            chStateNext[k] = chState[k];
            chDataNext[k]  = chData[k];
            if (acc && (bus.iSel == 2'(k))) begin
                chStateNext[k] = FULL;
                chDataNext[k]  = bus.iData;
            end else if (validVec[k] && bus.iReady[k]) begin
                chStateNext[k] = EMPTY;
            end
        end
        if (acc) begin
            lastSelNext = 4'b0001 << bus.iSel;
            accCntNext  = accCnt + CNT_W'(1);
        end
    end

    // State registers. Reset discards any buffered words.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int k = 0; k < 4; k++) begin
                chState[k] <= EMPTY;
                chData[k]  <= '0;
            end
            lastSel <= 4'b0000;
            accCnt  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                chState[k] <= chStateNext[k];
                chData[k]  <= chDataNext[k];
            end
            lastSel <= lastSelNext;
            accCnt  <= accCntNext;
        end
    end
endmodule

// File: tb/tb_pri_decoder_demux.sv
// Directed bench for pri_decoder_demux: a vector table for routing,
// back-pressure and independence, then hand-written sequences for back-to-back
// streaming, asynchronous reset and counter wrap.
module tb_pri_decoder_demux;
    logic iClk;
    logic iRst_n;

    pri_decoder_demux_if #(.DATA_W(1), .CNT_W(8)) bus ();

    pri_decoder_demux #(.DATA_W(1), .CNT_W(8)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    // Clock and reset
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver
    task automatic drive(input logic v, input logic [1:0] sel, input logic d, input logic [3:0] rdy);
        bus.iValid = v;
        bus.iSel   = sel;
        bus.iData  = d;
        bus.iReady = rdy;
    endtask

    function automatic logic [3:0] dataVec();
        return {bus.oData3, bus.oData2, bus.oData1, bus.oData0};
    endfunction

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic       d;
        logic [3:0] rdy;
        logic       expReady;
        logic [3:0] expValid;
        logic [3:0] expLast;
        logic [7:0] expCnt;
        logic [3:0] expData;   // {d3,d2,d1,d0}
    } vec_t;

    vec_t vecs[10];
    logic expQ[$];
    logic [9:0] pattern;
    logic expWord;

    initial begin
        // Routing with every consumer ready
        vecs[0] = '{1'b1, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b0001, 4'b0001, 8'd1, 4'b0001};
        vecs[1] = '{1'b1, 2'd1, 1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0010, 8'd2, 4'b0001};
        vecs[2] = '{1'b1, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0100, 8'd3, 4'b0101};
        vecs[3] = '{1'b1, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b1000, 4'b1000, 8'd4, 4'b1101};
        // Ch2 stalls: first word is taken, the second is refused and ch2 holds
        vecs[4] = '{1'b0, 2'd0, 1'b0, 4'b1011, 1'b1, 4'b0000, 4'b1000, 8'd4, 4'b1101};
        vecs[5] = '{1'b1, 2'd2, 1'b0, 4'b1011, 1'b1, 4'b0100, 4'b0100, 8'd5, 4'b1001};
        vecs[6] = '{1'b1, 2'd2, 1'b1, 4'b1011, 1'b0, 4'b0100, 4'b0100, 8'd5, 4'b1001};
        // Ch2 still stalled: a word for ch0 goes through
        vecs[7] = '{1'b1, 2'd0, 1'b0, 4'b1010, 1'b1, 4'b0101, 4'b0001, 8'd6, 4'b1000};
        // Ch2 drains and refills in the same cycle
        vecs[8] = '{1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 4'b0101, 4'b0100, 8'd7, 4'b1100};
        vecs[9] = '{1'b0, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0100, 8'd7, 4'b1100};

        iRst_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 4'b0000);
        #1;
        check("rst_valid", 32'(bus.oValid), 32'h0);
        check("rst_cnt", 32'(bus.oAccCnt), 32'h0);
        check("rst_last", 32'(bus.oLastSel), 32'h0);
        check("rst_data", 32'(dataVec()), 32'h0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;

        // Table-driven vectors: drive on negedge, oReady before the edge,
        // registered outputs on the following negedge.
        for (int i = 0; i < 10; i++) begin
            @(negedge iClk);
            drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].rdy);
            #1;
            check($sformatf("v%0d_ready", i), 32'(bus.oReady), 32'(vecs[i].expReady));
            @(negedge iClk);
            check($sformatf("v%0d_valid", i), 32'(bus.oValid), 32'(vecs[i].expValid));
            check($sformatf("v%0d_last", i), 32'(bus.oLastSel), 32'(vecs[i].expLast));
            check($sformatf("v%0d_cnt", i), 32'(bus.oAccCnt), 32'(vecs[i].expCnt));
            check($sformatf("v%0d_data", i), 32'(dataVec()), 32'(vecs[i].expData));
            drive(1'b0, 2'd0, 1'b0, vecs[i].rdy);
        end

        // Back-to-back on ch3: ten words, each must arrive in order
        pattern = 10'b1011001110;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd3, pattern[i], 4'b1000);
            #1;
            check($sformatf("b2b%0d_ready", i), 32'(bus.oReady), 32'h1);
            if (bus.oValid[3] === 1'b0 || i == 0) begin
                // first word fills an empty channel
            end
            expQ.push_back(pattern[i]);
            @(negedge iClk);
            check($sformatf("b2b%0d_valid3", i), 32'(bus.oValid[3]), 32'h1);
            expWord = expQ.pop_front();
            check($sformatf("b2b%0d_data3", i), 32'(bus.oData3), 32'(expWord));
        end
        drive(1'b0, 2'd0, 1'b0, 4'b1111);
        @(negedge iClk);
        check("b2b_cnt", 32'(bus.oAccCnt), 32'd17);
        check("b2b_drained", 32'(bus.oValid), 32'h0);

        // Asynchronous reset with ch1 full and stalled
        drive(1'b1, 2'd1, 1'b1, 4'b1101);
        @(negedge iClk);
        check("pre_rst_valid", 32'(bus.oValid), 32'b0010);
        drive(1'b0, 2'd0, 1'b0, 4'b0000);
        #2;
        iRst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.oValid), 32'h0);
        check("arst_cnt", 32'(bus.oAccCnt), 32'h0);
        check("arst_last", 32'(bus.oLastSel), 32'h0);
        check("arst_data", 32'(dataVec()), 32'h0);
        @(negedge iClk);
        iRst_n = 1'b1;

        // Counter wrap: 257 accepts from zero ends at 1
        for (int i = 0; i < 257; i++) begin
            if (i == 256) check("wrap_256", 32'(bus.oAccCnt), 32'h0);
            drive(1'b1, 2'(i % 4), 1'(i), 4'b1111);
            @(negedge iClk);
        end
        drive(1'b0, 2'd0, 1'b0, 4'b1111);
        check("wrap_cnt", 32'(bus.oAccCnt), 32'h1);
        check("wrap_last", 32'(bus.oLastSel), 32'b0001);
        @(negedge iClk);
        check("idle_cnt_hold", 32'(bus.oAccCnt), 32'h1);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
